// File: rtl/axis_byte_serializer_if.sv
// Bundle of the serializer's stream and status signals.
// The "slave" modport is the serializer's own view: it receives 32-bit words
// and the downstream ready, and it produces bytes, the input ready and the
// packet counter. The "master" modport is the view of whatever surrounds it.
interface axis_byte_serializer_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      S_AXIS_TDATA;
  logic [3:0]       S_AXIS_TSTRB;
  logic             S_AXIS_TKEEP;
  logic             S_AXIS_TLAST;
  logic             S_AXIS_TVALID;
  logic             S_AXIS_TREADY;
  logic [7:0]       M_AXIS_TDATA;
  logic             M_AXIS_TLAST;
  logic             M_AXIS_TVALID;
  logic             M_AXIS_TREADY;
  logic [CNT_W-1:0] STAT_PKT_CNT;

  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TKEEP, S_AXIS_TLAST, S_AXIS_TVALID,
    input  M_AXIS_TREADY,
    output S_AXIS_TREADY,
    output M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TVALID,
    output STAT_PKT_CNT
  );

  modport master (
    output S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TKEEP, S_AXIS_TLAST, S_AXIS_TVALID,
    output M_AXIS_TREADY,
    input  S_AXIS_TREADY,
    input  M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TVALID,
    input  STAT_PKT_CNT
  );
endinterface

// File: rtl/axis_byte_serializer.sv
// 32-bit to 8-bit AXI-Stream serializer.
// Holds one word at a time and emits only its strobed byte lanes, one per
// cycle, in lane order (low-to-high or high-to-low). TLAST rides on the last
// emitted byte of a packet; a strobe-less TLAST word becomes a single 0x00
// byte so the packet still closes. Input ready is combinational from the
// downstream ready on the final byte, so consecutive words flow without gaps.
module axis_byte_serializer #(
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input logic                  CLK,
  input logic                  RST,
  axis_byte_serializer_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      data_q, data_d;
  logic [3:0]       mask_q, mask_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       lane_idx;
  logic             one_left;
  logic [7:0]       lane_byte;
  logic             m_valid;
  logic             m_last;
  logic             s_ready;
  logic             m_fire;
  logic             s_fire;
  logic             unused_tkeep;

  // TKEEP is carried on the bus but has no meaning for this block.
  assign unused_tkeep = bus.S_AXIS_TKEEP;

  // Pick the next lane to emit: lowest set mask bit, or highest when sending MSB first.
  always_comb begin
    lane_idx = 2'd0;
    if (LSB_FIRST) begin
      for (int i = 3; i >= 0; i--) begin
        if (mask_q[i]) lane_idx = 2'(i);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) lane_idx = 2'(i);
      end
    end
  end

  // Output-side view of the held word and the two handshakes.
  always_comb begin
    one_left  = (mask_q != 4'd0) && ((mask_q & (mask_q - 4'd1)) == 4'd0);
    lane_byte = (mask_q == 4'd0) ? 8'h00 : data_q[{lane_idx, 3'b000} +: 8];
    m_valid   = (state_q == SHIFT);
    m_last    = m_valid && last_q && one_left;
    s_ready   = (state_q == EMPTY) || (bus.M_AXIS_TREADY && one_left);
    m_fire    = m_valid && bus.M_AXIS_TREADY;
    s_fire    = bus.S_AXIS_TVALID && s_ready;
  end

  assign bus.S_AXIS_TREADY = s_ready;
  assign bus.M_AXIS_TVALID = m_valid;
  assign bus.M_AXIS_TDATA  = lane_byte;
  assign bus.M_AXIS_TLAST  = m_last;
  assign bus.STAT_PKT_CNT  = cnt_q;

  // Next state: retire the emitted lane, then load any accepted word on top.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    if (m_fire) begin
      mask_d = mask_q & ~(4'b0001 << lane_idx);
      if (one_left) state_d = EMPTY;
      if (m_last) cnt_d = cnt_q + 1'b1;
    end

    if (s_fire) begin
      if (bus.S_AXIS_TSTRB != 4'd0) begin
        data_d  = bus.S_AXIS_TDATA;
        mask_d  = bus.S_AXIS_TSTRB;
        last_d  = bus.S_AXIS_TLAST;
        state_d = SHIFT;
      end else if (bus.S_AXIS_TLAST) begin
        data_d  = 32'd0;
        mask_d  = 4'b0001;
        last_d  = 1'b1;
        state_d = SHIFT;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // State register with synchronous reset that discards any held word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= EMPTY;
      data_q  <= 32'd0;
      mask_q  <= 4'd0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/axis_byte_serializer.md
Name: axis_byte_serializer

Overview:
- AXI-Stream slave that sits directly downstream of the 32-bit stream source.
- Accepts 32-bit words and re-emits only the bytes whose TSTRB lane is set, as an 8-bit AXI-Stream, one byte per cycle.
- Packet boundaries (TLAST) are preserved on the last emitted byte of each packet.
- Also counts completed output packets for status readback.

Parameters:
- LSB_FIRST, 1: 1 emits byte lanes 0→3 (TDATA[7:0] first); 0 emits lanes 3→0.
- CNT_W, 16: width of the completed-packet counter.

Ports:
- CLK  in  1  single clock for all logic.
- RST  in  1  synchronous active-high reset.
- S_AXIS_TDATA  in  32  input word.
- S_AXIS_TSTRB  in  4  byte-lane valid mask; bit n qualifies TDATA[8n+7:8n].
- S_AXIS_TKEEP  in  1  accepted, ignored (upstream drives 0).
- S_AXIS_TLAST  in  1  last word of packet.
- S_AXIS_TVALID  in  1  input word valid.
- S_AXIS_TREADY  out  1  block can accept a word this cycle.
- M_AXIS_TDATA  out  8  output byte.
- M_AXIS_TLAST  out  1  last byte of packet.
- M_AXIS_TVALID  out  1  output byte valid.
- M_AXIS_TREADY  in  1  downstream accepts byte.
- STAT_PKT_CNT  out  CNT_W  number of output bytes transferred with TLAST=1; wraps to 0.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high. All state updates on the rising edge of CLK.
- Reset values: M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, STAT_PKT_CNT=0, internal state EMPTY, holding word=0, mask=0, last flag=0. S_AXIS_TREADY=1 after reset (combinational from state).
- Reset mid-operation: any held word and its remaining bytes are discarded, with no partial TLAST. M_AXIS_TVALID is 0 on the cycle after RST is sampled high.
- State EMPTY:
  - S_AXIS_TREADY=1, M_AXIS_TVALID=0.
  - Word accepted (TVALID&TREADY) with TSTRB≠0: load word, mask=TSTRB, last flag=TLAST; go to SHIFT.
  - Accepted word with TSTRB=0 and TLAST=0: dropped; stay EMPTY.
  - Accepted word with TSTRB=0 and TLAST=1 (null-last): load data=0, mask=4'b0001, last flag=1; go to SHIFT. This emits a single 0x00 byte so the packet is closed.
- State SHIFT:
  - M_AXIS_TVALID=1.
  - M_AXIS_TDATA = lane at the lowest set mask bit (LSB_FIRST=1) or the highest set mask bit (LSB_FIRST=0).
  - M_AXIS_TLAST = last flag AND mask has exactly one bit set.
  - On M handshake, clear the emitted lane's mask bit.
  - M_AXIS_TDATA/TLAST hold stable while TVALID=1 and TREADY=0.
- Input ready in SHIFT: S_AXIS_TREADY = M_AXIS_TREADY AND mask has exactly one bit set. This is combinational from M_AXIS_TREADY (no skid buffer).
- Simultaneous final-byte handshake and input accept: the new word is loaded with the same rules as EMPTY, so there are no bubble cycles between words. If the new word is dropped (TSTRB=0, TLAST=0), go to EMPTY.
- Final byte consumed with no input accepted: go to EMPTY.
- Latency and throughput:
  - First byte of an accepted word is valid on the cycle after acceptance (1-cycle latency).
  - Sustained throughput is 1 byte/cycle while M_AXIS_TREADY=1.
  - A word with k strobed lanes occupies k output cycles.
- Non-contiguous strobes (e.g. 4'b1010): only set lanes are emitted, in lane order; gaps produce no cycles.
- STAT_PKT_CNT: increments by 1 on each M handshake with M_AXIS_TLAST=1; wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, then 2-word packet {0x44332211 strb F, 0x88776655 strb F, TLAST on word 2}, M_TREADY=1 → bytes 11,22,33,44,55,66,77,88 on 8 consecutive cycles; TLAST only on 0x88; STAT_PKT_CNT=1; no bubbles between words.
- LSB_FIRST=0, single word 0xAABBCCDD strb 4'b1010 TLAST=1 → output AA then CC, TLAST on CC, exactly 2 cycles.
- Backpressure: M_TREADY toggles 1,0,0,1,... during a 0x04030201 strb F word → each byte held stable while stalled; S_AXIS_TREADY=0 until the last byte's handshake cycle; output order 01,02,03,04.
- Strobe edge cases: word strb 0 TLAST=0 → no output, next word proceeds normally. Word strb 0 TLAST=1 → single byte 0x00 with TLAST=1, STAT_PKT_CNT increments.
- Assert RST for 1 cycle after 2 of 4 bytes of a TLAST word are emitted → M_TVALID=0 next cycle, STAT_PKT_CNT=0, S_AXIS_TREADY=1. A new word 0x000000EE strb 1 TLAST=1 then emits EE with TLAST.
- CNT_W=2: send 5 single-byte packets → STAT_PKT_CNT sequence 1,2,3,0,1.
